// File: rtl/regfile_pkg.sv
// Shared sizing helpers and default build constants for the multi-port register file.
package regfile_pkg;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ZERO_REG = 31;
  // Any ZERO_REG equal to DEPTH disables the hard-wired zero; this is the value for the default depth.
  localparam int ZERO_REG_OFF = DEF_DEPTH;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus an incrementally maintained count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int ADDR_W  = addr_w(DEPTH),
  localparam int CNT_W   = cnt_w(DEPTH)
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic              IssueVld,
  input  logic [ADDR_W-1:0] IssueReg,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] RW,
  output logic [DEPTH-1:0]  Busy,
  output logic [CNT_W-1:0]  PendCnt
);

  logic [DEPTH-1:0] setHit;
  logic [DEPTH-1:0] clrHit;
  logic [DEPTH-1:0] busyNext;
  logic             incr;
  logic             decr;

  // Issue beats a same-index write: the newer producer keeps the register busy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gBit
    assign setHit[gi]   = IssueVld && (IssueReg == ADDR_W'(gi)) && (gi != ZERO_REG);
    assign clrHit[gi]   = RegWr && (RW == ADDR_W'(gi));
    assign busyNext[gi] = setHit[gi] | (Busy[gi] & ~clrHit[gi]);
  end

  assign incr = |(setHit & ~Busy);
  assign decr = |(clrHit & Busy & ~setHit);

  always_ff @(negedge Clk) begin
    if (!ResetL) begin
      Busy    <= '0;
      PendCnt <= '0;
    end else begin
      Busy <= busyNext;
      case ({incr, decr})
        2'b10:   PendCnt <= PendCnt + CNT_W'(1);
        2'b01:   PendCnt <= PendCnt - CNT_W'(1);
        default: PendCnt <= PendCnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with optional write-to-read bypass and a pending-write scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = addr_w(DEPTH),
  localparam int CNT_W   = cnt_w(DEPTH)
) (
  input  logic                     Clk,
  input  logic                     ResetL,
  input  logic [WIDTH-1:0]         BusW,
  input  logic [ADDR_W-1:0]        RW,
  input  logic                     RegWr,
  input  logic                     IssueVld,
  input  logic [ADDR_W-1:0]        IssueReg,
  input  logic [NUM_RD*ADDR_W-1:0] RAddr,
  output logic [NUM_RD*WIDTH-1:0]  RData,
  output logic [NUM_RD-1:0]        RBusy,
  output logic [CNT_W-1:0]         PendCnt
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wrValid;

  assign wrValid = RegWr && (int'(RW) < DEPTH) && (int'(RW) != ZERO_REG);

  always_ff @(negedge Clk) begin
    if (!ResetL) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrValid) begin
      regs[RW] <= BusW;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) uScoreboard (
    .Clk      (Clk),
    .ResetL   (ResetL),
    .IssueVld (IssueVld),
    .IssueReg (IssueReg),
    .RegWr    (RegWr),
    .RW       (RW),
    .Busy     (busy),
    .PendCnt  (PendCnt)
  );

  // A forwarded port sees the write data now, so it must not also report the register busy.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : gRead
    logic [ADDR_W-1:0] rAddr;
    logic              rdValid;
    logic              fwdHit;

    assign rAddr   = RAddr[gi*ADDR_W +: ADDR_W];
    assign rdValid = (int'(rAddr) < DEPTH) && (int'(rAddr) != ZERO_REG);
    assign fwdHit  = BYPASS && RegWr && (RW == rAddr);

    assign RData[gi*WIDTH +: WIDTH] = !rdValid ? '0 : (fwdHit ? BusW : regs[rAddr]);
    assign RBusy[gi]                = rdValid && !fwdHit && busy[rAddr];
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Checks two builds (32-deep bypassed 4-port, 24-deep unbypassed 2-port) against a behavioural model.
module tb_regfile_mp_sb;

  logic         Clk = 1'b0;
  logic         ResetL;
  logic [63:0]  BusW;
  logic [4:0]   RW;
  logic         RegWr;
  logic         IssueVld;
  logic [4:0]   IssueReg;
  logic [4:0]   ra [4];

  logic [19:0]  RAddrA;
  logic [9:0]   RAddrB;
  logic [255:0] RDataA;
  logic [3:0]   RBusyA;
  logic [5:0]   PendA;
  logic [127:0] RDataB;
  logic [1:0]   RBusyB;
  logic [4:0]   PendB;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = build A, index 1 = build B
  logic [63:0] mRegs [2][32];
  bit          mBusy [2][32];
  bit          modelArmed = 0;
  int          depthOf [2] = '{32, 24};
  bit          bypOf   [2] = '{1'b1, 1'b0};
  localparam int ZR = 31;

  assign RAddrA = {ra[3], ra[2], ra[1], ra[0]};
  assign RAddrB = {ra[1], ra[0]};

  always #5 Clk = ~Clk;

  regfile_mp_sb #(
    .WIDTH(64), .DEPTH(32), .NUM_RD(4), .ZERO_REG(31), .BYPASS(1)
  ) dutA (
    .Clk(Clk), .ResetL(ResetL), .BusW(BusW), .RW(RW), .RegWr(RegWr),
    .IssueVld(IssueVld), .IssueReg(IssueReg), .RAddr(RAddrA),
    .RData(RDataA), .RBusy(RBusyA), .PendCnt(PendA)
  );

  regfile_mp_sb #(
    .WIDTH(64), .DEPTH(24), .NUM_RD(2), .ZERO_REG(31), .BYPASS(0)
  ) dutB (
    .Clk(Clk), .ResetL(ResetL), .BusW(BusW), .RW(RW), .RegWr(RegWr),
    .IssueVld(IssueVld), .IssueReg(IssueReg), .RAddr(RAddrB),
    .RData(RDataB), .RBusy(RBusyB), .PendCnt(PendB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit addrOk(int k, logic [4:0] a);
    return (int'(a) < depthOf[k]) && (int'(a) != ZR);
  endfunction

  function automatic logic [63:0] expRead(int k, logic [4:0] a);
    if (!addrOk(k, a)) return 64'd0;
    if (bypOf[k] && RegWr && RW == a) return BusW;
    return mRegs[k][a];
  endfunction

  function automatic logic expBusy(int k, logic [4:0] a);
    if (!addrOk(k, a)) return 1'b0;
    if (bypOf[k] && RegWr && RW == a) return 1'b0;
    return mBusy[k][a];
  endfunction

  function automatic int expPend(int k);
    int n = 0;
    for (int r = 0; r < 32; r++) n += mBusy[k][r];
    return n;
  endfunction

  // Compare every output of both builds against the model for the currently driven inputs.
  task automatic settle();
    #1;
    if (modelArmed) begin
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("A_rdata%0d", p), RDataA[p*64 +: 64], expRead(0, ra[p]));
        chk($sformatf("A_rbusy%0d", p), 64'(RBusyA[p]), 64'(expBusy(0, ra[p])));
      end
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("B_rdata%0d", p), RDataB[p*64 +: 64], expRead(1, ra[p]));
        chk($sformatf("B_rbusy%0d", p), 64'(RBusyB[p]), 64'(expBusy(1, ra[p])));
      end
      chk("A_pendcnt", 64'(PendA), 64'(expPend(0)));
      chk("B_pendcnt", 64'(PendB), 64'(expPend(1)));
    end
  endtask

  task automatic clkEdge();
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      if (!ResetL) begin
        for (int r = 0; r < 32; r++) begin
          mRegs[k][r] = 64'd0;
          mBusy[k][r] = 1'b0;
        end
      end else begin
        if (RegWr && addrOk(k, RW)) mRegs[k][RW] = BusW;
        if (RegWr && int'(RW) < depthOf[k]) mBusy[k][RW] = 1'b0;
        if (IssueVld && addrOk(k, IssueReg)) mBusy[k][IssueReg] = 1'b1;
      end
    end
    if (!ResetL) modelArmed = 1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ResetL = 1'b0; BusW = '0; RW = '0; RegWr = 1'b0; IssueVld = 1'b0; IssueReg = '0;
    for (int p = 0; p < 4; p++) ra[p] = 5'd0;
    #2;
    clkEdge();
    clkEdge();

    // Writes to the zero register are dropped
    ResetL = 1'b1; RegWr = 1'b1; RW = 5'd31; BusW = 64'h12345678;
    for (int p = 0; p < 4; p++) ra[p] = 5'd31;
    settle();
    chk("t1_A_x31", RDataA[3*64 +: 64], 64'd0);
    chk("t1_A_pend", 64'(PendA), 64'd0);
    clkEdge();
    RegWr = 1'b0;
    settle();
    chk("t1_A_x31_after", RDataA[0 +: 64], 64'd0);
    clkEdge();

    // Fill X0..X30 with their own index
    for (int n = 0; n <= 30; n++) begin
      RegWr = 1'b1; RW = 5'(n); BusW = 64'(n);
      settle();
      clkEdge();
    end
    RegWr = 1'b0;
    ra[0] = 5'd0; ra[1] = 5'd1; ra[2] = 5'd30; ra[3] = 5'd31;
    settle();
    chk("t2_x0", RDataA[0*64 +: 64], 64'd0);
    chk("t2_x1", RDataA[1*64 +: 64], 64'd1);
    chk("t2_x30", RDataA[2*64 +: 64], 64'h1E);
    chk("t2_x31", RDataA[3*64 +: 64], 64'd0);
    clkEdge();

    // Bypass versus registered read
    RegWr = 1'b1; RW = 5'd5; BusW = 64'hABCD; ra[0] = 5'd5;
    settle();
    chk("t3_A_bypass", RDataA[0 +: 64], 64'hABCD);
    chk("t3_B_old", RDataB[0 +: 64], 64'd5);
    clkEdge();
    RegWr = 1'b0;
    settle();
    chk("t3_B_new", RDataB[0 +: 64], 64'hABCD);
    clkEdge();

    // Scoreboard set / issue-wins / clear
    IssueVld = 1'b1; IssueReg = 5'd10; ra[0] = 5'd10;
    settle();
    clkEdge();
    IssueVld = 1'b0;
    settle();
    chk("t4_busy_set", 64'(RBusyA[0]), 64'd1);
    chk("t4_pend1", 64'(PendA), 64'd1);
    clkEdge();
    IssueVld = 1'b1; IssueReg = 5'd10; RegWr = 1'b1; RW = 5'd10; BusW = 64'h1010;
    settle();
    clkEdge();
    IssueVld = 1'b0; RegWr = 1'b0;
    settle();
    chk("t4_busy_kept", 64'(RBusyA[0]), 64'd1);
    chk("t4_pend_kept", 64'(PendA), 64'd1);
    chk("t4_x10", RDataA[0 +: 64], 64'h1010);
    clkEdge();
    RegWr = 1'b1; RW = 5'd10; BusW = 64'h2020;
    settle();
    clkEdge();
    RegWr = 1'b0;
    settle();
    chk("t4_busy_clr", 64'(RBusyA[0]), 64'd0);
    chk("t4_pend0", 64'(PendA), 64'd0);
    clkEdge();

    // Reset discards pending state and dominates a same-edge write
    for (int r = 2; r <= 4; r++) begin
      IssueVld = 1'b1; IssueReg = 5'(r);
      settle();
      clkEdge();
    end
    IssueVld = 1'b0;
    settle();
    chk("t5_A_pend3", 64'(PendA), 64'd3);
    chk("t5_B_pend3", 64'(PendB), 64'd3);
    clkEdge();
    ResetL = 1'b0; RegWr = 1'b1; RW = 5'd2; BusW = 64'd7;
    ra[0] = 5'd2; ra[1] = 5'd3; ra[2] = 5'd4; ra[3] = 5'd10;
    clkEdge();
    ResetL = 1'b1; RegWr = 1'b0;
    settle();
    chk("t5_pend0", 64'(PendA), 64'd0);
    chk("t5_x2", RDataA[0 +: 64], 64'd0);
    chk("t5_rbusy", 64'(RBusyA), 64'd0);
    clkEdge();

    // Out-of-range and zero register on the 24-deep build
    IssueVld = 1'b1; IssueReg = 5'd31; RegWr = 1'b1; RW = 5'd24; BusW = 64'hDEAD;
    ra[0] = 5'd24; ra[1] = 5'd31;
    settle();
    clkEdge();
    IssueVld = 1'b0; RegWr = 1'b0;
    settle();
    chk("t6_B_pend", 64'(PendB), 64'd0);
    chk("t6_B_rdata", RDataB[0 +: 64], 64'd0);
    chk("t6_B_rbusy", 64'(RBusyB), 64'd0);
    clkEdge();

    // Randomised traffic, biased so reads often hit the written register
    for (int c = 0; c < 400; c++) begin
      ResetL   = ($urandom_range(0, 63) != 0);
      RegWr    = $urandom_range(0, 1);
      RW       = 5'($urandom_range(0, 31));
      BusW     = {$urandom(), $urandom()};
      IssueVld = $urandom_range(0, 1);
      IssueReg = ($urandom_range(0, 3) == 0) ? RW : 5'($urandom_range(0, 31));
      for (int p = 0; p < 4; p++)
        ra[p] = ($urandom_range(0, 2) == 0) ? RW : 5'($urandom_range(0, 31));
      settle();
      clkEdge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
